// File: rtl/mdu_issue_arb_if.sv
// Requester-side and MDU-side signals of the MDU issue arbiter.
// slave = arbiter view, master = requesters/MDU view.
interface mdu_issue_arb_if #(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 4,
   parameter int OPC_W   = 3
);
   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req_i;
   logic [NUM_REQ-1:0]        rdy_o;
   logic [NUM_REQ*OPC_W-1:0]  opc_i;
   logic [NUM_REQ*DATA_W-1:0] src1_i;
   logic [NUM_REQ*DATA_W-1:0] src2_i;
   logic [NUM_REQ*TAG_W-1:0]  tag_i;

   logic                      mdu_req;
   logic                      mdu_rdy;
   logic [OPC_W-1:0]          mdu_opc;
   logic [DATA_W-1:0]         mdu_src1;
   logic [DATA_W-1:0]         mdu_src2;
   logic [TAG_W-1:0]          mdu_tag;
   logic [IDX_W-1:0]          gnt_idx;

   modport slave (
      input  req_i, opc_i, src1_i, src2_i, tag_i, mdu_rdy,
      output rdy_o, mdu_req, mdu_opc, mdu_src1, mdu_src2, mdu_tag, gnt_idx
   );

   modport master (
      output req_i, opc_i, src1_i, src2_i, tag_i, mdu_rdy,
      input  rdy_o, mdu_req, mdu_opc, mdu_src1, mdu_src2, mdu_tag, gnt_idx
   );
endinterface

// File: rtl/mdu_issue_arb.sv
// Round-robin arbiter + one-entry issue register feeding the shared MDU; 1-cycle grant-to-mdu_req latency.
// Backpressure: holds the op while mdu_rdy=0 and grants only when the register is empty or draining.
module mdu_issue_arb #(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 4,
   parameter int OPC_W   = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   mdu_issue_arb_if.slave        bus
);
   localparam int IDX_W = $clog2(NUM_REQ);

   typedef struct packed {
      logic [OPC_W-1:0]  opc;
      logic [DATA_W-1:0] src1;
      logic [DATA_W-1:0] src2;
      logic [TAG_W-1:0]  tag;
   } op_t;

   op_t              req_op [NUM_REQ];
   op_t              op_q, op_d;
   logic             v_q, v_d;
   logic [IDX_W-1:0] rr_q, rr_d;
   logic [IDX_W-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0] win, cand;
   logic [IDX_W:0]   sum;
   logic             found, can_take, grant;
   logic [NUM_REQ-1:0] gnt_oh;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_op[g] = {bus.opc_i[g*OPC_W +: OPC_W],
                          bus.src1_i[g*DATA_W +: DATA_W],
                          bus.src2_i[g*DATA_W +: DATA_W],
                          bus.tag_i[g*TAG_W +: TAG_W]};
   end

   // Scan rr_q, rr_q+1, ... modulo NUM_REQ; first active request wins.
   always_comb begin
      found = 1'b0;
      win   = '0;
      sum   = '0;
      cand  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum = {1'b0, rr_q} + (IDX_W+1)'(i);
         if (sum >= (IDX_W+1)'(NUM_REQ)) begin
            sum = sum - (IDX_W+1)'(NUM_REQ);
         end
         cand = sum[IDX_W-1:0];
         if (!found && bus.req_i[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   assign can_take = ~flush & (~v_q | (v_q & bus.mdu_rdy));
   assign grant    = can_take & found;

   always_comb begin
      gnt_oh = '0;
      v_d    = v_q;
      op_d   = op_q;
      rr_d   = rr_q;
      gnt_d  = gnt_q;
      if (grant && rst_n) begin
         gnt_oh[win] = 1'b1;
      end
      if (flush) begin
         v_d = 1'b0;
      end else if (grant) begin
         v_d   = 1'b1;
         op_d  = req_op[win];
         gnt_d = win;
         rr_d  = (win == IDX_W'(NUM_REQ-1)) ? '0 : win + IDX_W'(1);
      end else if (v_q && bus.mdu_rdy) begin
         v_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q   <= 1'b0;
         op_q  <= '0;
         rr_q  <= '0;
         gnt_q <= '0;
      end else begin
         v_q   <= v_d;
         op_q  <= op_d;
         rr_q  <= rr_d;
         gnt_q <= gnt_d;
      end
   end

   assign bus.rdy_o    = gnt_oh;
   assign bus.mdu_req  = v_q;
   assign bus.mdu_opc  = op_q.opc;
   assign bus.mdu_src1 = op_q.src1;
   assign bus.mdu_src2 = op_q.src2;
   assign bus.mdu_tag  = op_q.tag;
   assign bus.gnt_idx  = gnt_q;
endmodule

// File: tb/tb_mdu_issue_arb.sv
// Directed bench for mdu_issue_arb; expected ops are queued on each expected grant and
// compared against the issue register while it is expected to be valid.
module tb_mdu_issue_arb;
   localparam int NR = 2;
   localparam int DW = 32;
   localparam int TW = 4;
   localparam int OW = 3;

   typedef struct packed {
      logic [OW-1:0] opc;
      logic [DW-1:0] s1;
      logic [DW-1:0] s2;
      logic [TW-1:0] tag;
      logic          idx;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;
   int   compared   = 0;
   int   mismatched = 0;
   exp_t cur [NR];
   exp_t sb [$];

   mdu_issue_arb_if #(.NUM_REQ(NR), .DATA_W(DW), .TAG_W(TW), .OPC_W(OW)) bus ();

   mdu_issue_arb #(.NUM_REQ(NR), .DATA_W(DW), .TAG_W(TW), .OPC_W(OW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish before 200000");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic drive_ops();
      for (int k = 0; k < NR; k++) begin
         bus.opc_i[k*OW +: OW]  = cur[k].opc;
         bus.src1_i[k*DW +: DW] = cur[k].s1;
         bus.src2_i[k*DW +: DW] = cur[k].s2;
         bus.tag_i[k*TW +: TW]  = cur[k].tag;
      end
   endtask

   task automatic check_out(input string name);
      chk({name, ":mdu_req"}, 64'(bus.mdu_req), 64'(sb.size() != 0));
      if (sb.size() != 0) begin
         chk({name, ":mdu_tag"},  64'(bus.mdu_tag),  64'(sb[0].tag));
         chk({name, ":mdu_src1"}, 64'(bus.mdu_src1), 64'(sb[0].s1));
         chk({name, ":mdu_src2"}, 64'(bus.mdu_src2), 64'(sb[0].s2));
         chk({name, ":mdu_opc"},  64'(bus.mdu_opc),  64'(sb[0].opc));
         chk({name, ":gnt_idx"},  64'(bus.gnt_idx),  64'(sb[0].idx));
      end
   endtask

   // One clock cycle: drive, check rdy_o and issue register, then advance the expected state.
   task automatic step(input string name, input logic [1:0] req, input logic mrdy,
                       input logic fl, input logic [1:0] exp_rdy);
      exp_t e;
      @(negedge clk);
      bus.req_i   = req;
      bus.mdu_rdy = mrdy;
      flush       = fl;
      drive_ops();
      #1;
      chk({name, ":rdy_o"}, 64'(bus.rdy_o), 64'(exp_rdy));
      check_out(name);
      if (fl) begin
         sb.delete();
      end else if (sb.size() != 0 && mrdy) begin
         void'(sb.pop_front());
      end
      for (int k = 0; k < NR; k++) begin
         if (exp_rdy[k]) begin
            e     = cur[k];
            e.idx = k[0];
            sb.push_back(e);
            cur[k].tag = cur[k].tag + 4'd1;
            cur[k].s1  = cur[k].s1 + 32'd1;
            cur[k].s2  = cur[k].s2 + 32'd3;
            cur[k].opc = cur[k].opc + 3'd1;
         end
      end
   endtask

   initial begin
      cur[0] = '{opc: 3'd0, s1: 32'd7,     s2: 32'd6,    tag: 4'd3, idx: 1'b0};
      cur[1] = '{opc: 3'd1, s1: 32'h100,   s2: 32'h55,   tag: 4'd8, idx: 1'b1};
      rst_n       = 1'b0;
      flush       = 1'b0;
      bus.req_i   = 2'b01;
      bus.mdu_rdy = 1'b0;
      drive_ops();

      // reset state, with a request pending to see rdy_o gated
      #2;
      chk("rst:rdy_o",    64'(bus.rdy_o),    64'd0);
      chk("rst:mdu_req",  64'(bus.mdu_req),  64'd0);
      chk("rst:mdu_tag",  64'(bus.mdu_tag),  64'd0);
      chk("rst:mdu_src1", 64'(bus.mdu_src1), 64'd0);
      chk("rst:gnt_idx",  64'(bus.gnt_idx),  64'd0);
      @(negedge clk);
      bus.req_i = 2'b00;
      #1 rst_n = 1'b1;

      // first op, then drain + grant of requester 1
      step("t1_grant0", 2'b01, 1'b1, 1'b0, 2'b01);
      step("t1_grant1", 2'b10, 1'b1, 1'b0, 2'b10);

      // both requesting at full throughput: alternate 0,1,0,1
      step("t2_c0", 2'b11, 1'b1, 1'b0, 2'b01);
      step("t2_c1", 2'b11, 1'b1, 1'b0, 2'b10);
      step("t2_c2", 2'b11, 1'b1, 1'b0, 2'b01);
      step("t2_c3", 2'b11, 1'b1, 1'b0, 2'b10);

      // backpressure: nothing taken, outputs stable, then release grants req 1
      for (int c = 0; c < 5; c++) begin
         step($sformatf("t3_bp%0d", c), 2'b10, 1'b0, 1'b0, 2'b00);
      end
      step("t3_release", 2'b10, 1'b1, 1'b0, 2'b10);
      step("t3_show",    2'b00, 1'b1, 1'b0, 2'b00);

      // back-to-back: drain + grant, no bubble, then empty
      step("t4_g0",    2'b01, 1'b1, 1'b0, 2'b01);
      step("t4_g1",    2'b10, 1'b1, 1'b0, 2'b10);
      step("t4_drain", 2'b00, 1'b1, 1'b0, 2'b00);
      step("t4_empty", 2'b00, 1'b0, 1'b0, 2'b00);

      // flush with V=1: no grant, V cleared, rr_ptr (=1) kept
      step("t5_fill",  2'b01, 1'b0, 1'b0, 2'b01);
      step("t5_flush", 2'b11, 1'b0, 1'b1, 2'b00);
      step("t5_after", 2'b11, 1'b0, 1'b0, 2'b10);
      step("t5_g0",    2'b01, 1'b1, 1'b0, 2'b01);

      // async reset during backpressure with rr_ptr=1
      step("t6_bp", 2'b11, 1'b0, 1'b0, 2'b00);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst:mdu_req", 64'(bus.mdu_req), 64'd0);
      chk("t6_rst:rdy_o",   64'(bus.rdy_o),   64'd0);
      chk("t6_rst:mdu_tag", 64'(bus.mdu_tag), 64'd0);
      sb.delete();
      @(negedge clk);
      bus.req_i = 2'b00;
      #1 rst_n = 1'b1;
      step("t6_grant0", 2'b11, 1'b1, 1'b0, 2'b01);
      step("t6_show",   2'b00, 1'b1, 1'b0, 2'b00);
      step("t6_empty",  2'b00, 1'b1, 1'b0, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
